// File: rtl/fractal_sync_nary.sv
// N-ary barrier synchronisation node: collects child arrivals per barrier ID,
// completes locally or forwards upstream, and fans responses back to children.
module fractal_sync_nary #(
  parameter int unsigned N_CHILDREN = 4,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned LVL_WIDTH  = 4,
  parameter int unsigned NODE_LEVEL = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_CHILDREN-1:0]            req_valid_i,
  output logic [N_CHILDREN-1:0]            req_ready_o,
  input  logic [N_CHILDREN*ID_WIDTH-1:0]   req_id_i,
  input  logic [N_CHILDREN*LVL_WIDTH-1:0]  req_lvl_i,
  input  logic [N_CHILDREN*N_CHILDREN-1:0] req_aggr_i,
  output logic [N_CHILDREN-1:0]            rsp_valid_o,
  input  logic [N_CHILDREN-1:0]            rsp_ready_i,
  output logic [ID_WIDTH-1:0]              rsp_id_o,
  output logic                             rsp_err_o,
  output logic                             up_valid_o,
  input  logic                             up_ready_i,
  output logic [ID_WIDTH-1:0]              up_id_o,
  output logic [LVL_WIDTH-1:0]             up_lvl_o,
  input  logic                             dn_valid_i,
  input  logic [ID_WIDTH-1:0]              dn_id_i,
  input  logic                             dn_err_i,
  output logic                             err_dup_o,
  output logic                             err_mask_o,
  output logic                             err_dn_o
);

  localparam int unsigned N_BARRIERS = 2**ID_WIDTH;
  localparam int unsigned PW         = $clog2(N_CHILDREN);
  localparam int unsigned CW         = ID_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_PARENT, RESPOND} bar_state_e;

  bar_state_e            st_q   [N_BARRIERS];
  bar_state_e            st_d   [N_BARRIERS];
  logic [N_CHILDREN-1:0] exp_q  [N_BARRIERS];
  logic [N_CHILDREN-1:0] exp_d  [N_BARRIERS];
  logic [N_CHILDREN-1:0] arr_q  [N_BARRIERS];
  logic [N_CHILDREN-1:0] arr_d  [N_BARRIERS];
  logic [N_CHILDREN-1:0] pend_q [N_BARRIERS];
  logic [N_CHILDREN-1:0] pend_d [N_BARRIERS];
  logic [LVL_WIDTH-1:0]  lvl_q  [N_BARRIERS];
  logic [LVL_WIDTH-1:0]  lvl_d  [N_BARRIERS];
  logic [N_BARRIERS-1:0] err_q, err_d;

  logic [PW-1:0]         rr_q;
  logic                  gnt_vld;
  logic [PW-1:0]         gnt_idx;
  logic [ID_WIDTH-1:0]   g_id;
  logic [LVL_WIDTH-1:0]  g_lvl;
  logic [N_CHILDREN-1:0] g_mask, g_own, elig;

  logic [ID_WIDTH-1:0]   rsp_mem [N_BARRIERS];
  logic [ID_WIDTH-1:0]   up_mem  [N_BARRIERS];
  logic [ID_WIDTH-1:0]   rsp_rd_q, rsp_wr_q, up_rd_q, up_wr_q;
  logic [CW-1:0]         rsp_cnt_q, up_cnt_q;
  logic                  rsp_push, rsp_pop, up_push, up_pop;
  logic [ID_WIDTH-1:0]   rsp_push_id, up_push_id, rsp_head, up_head;
  logic                  rsp_nempty, up_nempty;

  logic                  done;
  logic [LVL_WIDTH-1:0]  done_lvl;
  logic [N_CHILDREN-1:0] arr_new, pend_left;
  logic                  err_dup_d, err_mask_d, err_dn_d;
  logic                  err_dup_q, err_mask_q, err_dn_q;

  // Outputs are gated by rst_ni so they read zero throughout reset.
  assign rsp_head   = rsp_mem[rsp_rd_q];
  assign up_head    = up_mem[up_rd_q];
  assign rsp_nempty = rst_ni && (rsp_cnt_q != '0);
  assign up_nempty  = rst_ni && (up_cnt_q != '0);

  assign rsp_valid_o = rsp_nempty ? pend_q[rsp_head] : '0;
  assign rsp_id_o    = rsp_nempty ? rsp_head : '0;
  assign rsp_err_o   = rsp_nempty && err_q[rsp_head];
  assign up_valid_o  = up_nempty;
  assign up_id_o     = up_nempty ? up_head : '0;
  assign up_lvl_o    = up_nempty ? lvl_q[up_head] : '0;
  assign up_pop      = up_nempty && up_ready_i;
  assign req_ready_o = g_own;
  assign err_dup_o   = err_dup_q;
  assign err_mask_o  = err_mask_q;
  assign err_dn_o    = err_dn_q;

  // Round-robin: first pass from rr_q upward, second pass wraps from 0.
  always_comb begin
    elig    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    g_id    = '0;
    g_lvl   = '0;
    g_mask  = '0;
    g_own   = '0;
    for (int unsigned i = 0; i < N_CHILDREN; i++) begin
      elig[i] = req_valid_i[i] &&
                (st_q[req_id_i[i*ID_WIDTH +: ID_WIDTH]] inside {IDLE, COLLECT});
    end
    if (rst_ni && !dn_valid_i) begin
      for (int unsigned i = 0; i < N_CHILDREN; i++) begin
        if (!gnt_vld && elig[i] && i >= 32'(rr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
      for (int unsigned i = 0; i < N_CHILDREN; i++) begin
        if (!gnt_vld && elig[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
      for (int unsigned i = 0; i < N_CHILDREN; i++) begin
        if (gnt_vld && gnt_idx == PW'(i)) begin
          g_own[i] = 1'b1;
          g_id     = req_id_i[i*ID_WIDTH +: ID_WIDTH];
          g_lvl    = req_lvl_i[i*LVL_WIDTH +: LVL_WIDTH];
          g_mask   = req_aggr_i[i*N_CHILDREN +: N_CHILDREN];
        end
      end
    end
  end

  always_comb begin
    st_d        = st_q;
    exp_d       = exp_q;
    arr_d       = arr_q;
    pend_d      = pend_q;
    lvl_d       = lvl_q;
    err_d       = err_q;
    rsp_push    = 1'b0;
    rsp_push_id = '0;
    rsp_pop     = 1'b0;
    up_push     = 1'b0;
    up_push_id  = '0;
    done        = 1'b0;
    done_lvl    = '0;
    arr_new     = '0;
    pend_left   = '0;
    err_dup_d   = 1'b0;
    err_mask_d  = 1'b0;
    err_dn_d    = 1'b0;

    if (gnt_vld) begin
      if (g_mask == '0 || (g_mask & g_own) == '0) begin
        err_mask_d = 1'b1;
      end else if (st_q[g_id] == IDLE) begin
        exp_d[g_id] = g_mask;
        lvl_d[g_id] = g_lvl;
        arr_d[g_id] = g_own;
        st_d[g_id]  = COLLECT;
        done        = (g_own == g_mask);
        done_lvl    = g_lvl;
      end else if (g_mask != exp_q[g_id]) begin
        err_mask_d = 1'b1;
      end else if ((arr_q[g_id] & g_own) != '0) begin
        err_dup_d = 1'b1;
      end else begin
        arr_new     = arr_q[g_id] | g_own;
        arr_d[g_id] = arr_new;
        done        = (arr_new == exp_q[g_id]);
        done_lvl    = lvl_q[g_id];
      end
      if (done) begin
        if (done_lvl == LVL_WIDTH'(NODE_LEVEL)) begin
          err_d[g_id]  = 1'b0;
          pend_d[g_id] = exp_d[g_id];
          st_d[g_id]   = RESPOND;
          rsp_push     = 1'b1;
          rsp_push_id  = g_id;
        end else begin
          st_d[g_id] = WAIT_PARENT;
          up_push    = 1'b1;
          up_push_id = g_id;
        end
      end
    end

    // dn_valid_i blocks grants, so at most one response push per cycle.
    if (dn_valid_i && rst_ni) begin
      if (st_q[dn_id_i] == WAIT_PARENT) begin
        err_d[dn_id_i]  = dn_err_i;
        pend_d[dn_id_i] = exp_q[dn_id_i];
        st_d[dn_id_i]   = RESPOND;
        rsp_push        = 1'b1;
        rsp_push_id     = dn_id_i;
      end else begin
        err_dn_d = 1'b1;
      end
    end

    if (rsp_nempty) begin
      pend_left        = pend_q[rsp_head] & ~rsp_ready_i;
      pend_d[rsp_head] = pend_left;
      if (pend_left == '0) begin
        rsp_pop          = 1'b1;
        st_d[rsp_head]   = IDLE;
        arr_d[rsp_head]  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < N_BARRIERS; b++) begin
        st_q[b]   <= IDLE;
        exp_q[b]  <= '0;
        arr_q[b]  <= '0;
        pend_q[b] <= '0;
        lvl_q[b]  <= '0;
      end
      err_q      <= '0;
      rr_q       <= '0;
      rsp_rd_q   <= '0;
      rsp_wr_q   <= '0;
      rsp_cnt_q  <= '0;
      up_rd_q    <= '0;
      up_wr_q    <= '0;
      up_cnt_q   <= '0;
      err_dup_q  <= 1'b0;
      err_mask_q <= 1'b0;
      err_dn_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      exp_q      <= exp_d;
      arr_q      <= arr_d;
      pend_q     <= pend_d;
      lvl_q      <= lvl_d;
      err_q      <= err_d;
      err_dup_q  <= err_dup_d;
      err_mask_q <= err_mask_d;
      err_dn_q   <= err_dn_d;
      if (gnt_vld) begin
        rr_q <= (gnt_idx == PW'(N_CHILDREN - 1)) ? '0 : gnt_idx + PW'(1);
      end
      if (rsp_push) rsp_wr_q <= rsp_wr_q + ID_WIDTH'(1);
      if (rsp_pop)  rsp_rd_q <= rsp_rd_q + ID_WIDTH'(1);
      rsp_cnt_q <= rsp_cnt_q + CW'(rsp_push) - CW'(rsp_pop);
      if (up_push) up_wr_q <= up_wr_q + ID_WIDTH'(1);
      if (up_pop)  up_rd_q <= up_rd_q + ID_WIDTH'(1);
      up_cnt_q <= up_cnt_q + CW'(up_push) - CW'(up_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsp_push) rsp_mem[rsp_wr_q] <= rsp_push_id;
    if (up_push)  up_mem[up_wr_q]   <= up_push_id;
  end

endmodule

// File: doc/fractal_sync_nary.md
FRACTAL_SYNC_NARY -- requirements
Module: fractal_sync_nary

Interface
REQ-001 SHALL have parameter N_CHILDREN, default 4, number of child request ports (2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 3, barrier ID width; N_BARRIERS = 2**ID_WIDTH entries.
REQ-003 SHALL have parameter LVL_WIDTH, default 4, level field width.
REQ-004 SHALL have parameter NODE_LEVEL, default 1, tree level of this node.
REQ-005 SHALL use one clock; reset is synchronous and active-low: clk_i, rst_ni.
REQ-006 Ports, in this order:
- clk_i  in  1  clock
- rst_ni  in  1  sync active-low reset
- req_valid_i  in  N_CHILDREN  child request valid
- req_ready_o  out  N_CHILDREN  child request accepted
- req_id_i  in  N_CHILDREN*ID_WIDTH  barrier ID per child
- req_lvl_i  in  N_CHILDREN*LVL_WIDTH  target level per child
- req_aggr_i  in  N_CHILDREN*N_CHILDREN  participating-child mask per child
- rsp_valid_o  out  N_CHILDREN  response valid
- rsp_ready_i  in  N_CHILDREN  response accepted
- rsp_id_o  out  ID_WIDTH  response ID (shared)
- rsp_err_o  out  1  response error flag (shared)
- up_valid_o  out  1  parent request valid
- up_ready_i  in  1  parent accepts
- up_id_o  out  ID_WIDTH  parent request ID
- up_lvl_o  out  LVL_WIDTH  parent request level
- dn_valid_i  in  1  parent response, always accepted
- dn_id_i  in  ID_WIDTH  parent response ID
- dn_err_i  in  1  parent response error
- err_dup_o  out  1  duplicate-arrival pulse
- err_mask_o  out  1  illegal/mismatched-mask pulse
- err_dn_o  out  1  unexpected-parent-response pulse

Function
REQ-007 Per-ID entry: state {IDLE, COLLECT, WAIT_PARENT, RESPOND}, expected mask, arrived mask, level, err bit.
REQ-008 Arbiter: at most one child request accepted per cycle; round-robin, pointer advances to grantee+1.
REQ-009 Eligible child: req_valid_i high, entry of its ID in IDLE or COLLECT; otherwise req_ready_o low (stall).
REQ-010 dn_valid_i high: all req_ready_o low that cycle.
REQ-011 Accepted request, aggr mask zero or own bit clear: err_mask_o pulses next cycle; request dropped; entry unchanged.
REQ-012 Accept in IDLE: latch mask and level, arrived = own bit, state COLLECT.
REQ-013 Accept in COLLECT, mask differs from latched: err_mask_o pulse, dropped.
REQ-014 Accept in COLLECT, own bit already arrived: err_dup_o pulse, dropped.
REQ-015 Completion when arrived == expected, same accept cycle; single-bit mask completes on first arrival.
REQ-016 Completion with level == NODE_LEVEL: err=0, ID pushed to response FIFO, state RESPOND.
REQ-017 Otherwise: ID pushed to up FIFO, state WAIT_PARENT.
REQ-018 Up FIFO depth N_BARRIERS, never overflows; head drives up_valid_o/up_id_o/up_lvl_o (entry level); pop on up_valid_o & up_ready_i; valid held stable until accepted.
REQ-019 dn_valid_i with entry in WAIT_PARENT: err = dn_err_i, push ID to response FIFO, state RESPOND.
REQ-020 dn_valid_i with entry not in WAIT_PARENT: err_dn_o pulse next cycle; ignored.
REQ-021 Response FIFO depth N_BARRIERS, one push per cycle max, never overflows.
REQ-022 Head: rsp_id_o = ID, rsp_err_o = entry err; rsp_valid_o[i] high for each child with pending bit (initialised to expected mask).
REQ-023 rsp_valid_o[i] & rsp_ready_i[i] clears bit i; when all clear: pop FIFO, entry to IDLE, arrived cleared, same cycle.
REQ-024 Latency: local completion at cycle t gives rsp_valid_o at t+1 if FIFO empty; up_valid_o at t+1 if up FIFO empty; dn at t gives rsp_valid_o at t+1 if FIFO empty.
REQ-025 Error outputs: single-cycle pulses, registered, cycle after the event.

Reset
REQ-026 rst_ni low at a clock edge: all entries IDLE, masks 0, FIFOs empty, RR pointer 0.
REQ-027 During and after reset: all outputs 0 (req_ready_o, rsp_valid_o, rsp_id_o, rsp_err_o, up_*, err_*).
REQ-028 Reset mid-operation discards collected and in-flight barriers; no response issued for them afterwards.

Verification
REQ-029 N_CHILDREN=4, NODE_LEVEL=1: children 0,2 send ID 5, lvl 1, mask 0101 in cycles 0,1 -> rsp_valid_o=0101, rsp_id_o=5, rsp_err_o=0 at cycle 2; up_valid_o stays 0.
REQ-030 All 4 children send ID 3, lvl 2, mask 1111 simultaneously -> grants in order 0,1,2,3 over 4 cycles; up_valid_o=1, up_id_o=3, up_lvl_o=2 one cycle after 4th grant; dn_valid_i ID 3, dn_err_i=1 -> rsp_valid_o=1111, rsp_err_o=1.
REQ-031 Child 1 sends ID 2 mask 0011 twice before child 0 -> second request: err_dup_o pulse; state still waits for child 0.
REQ-032 Child 0 mask 0011 then child 1 mask 0111 on ID 4 -> err_mask_o pulse; later child 1 mask 0011 completes.
REQ-033 dn_valid_i ID 6 while IDLE -> err_dn_o pulse, no rsp_valid_o; rsp_ready_i[2]=0 holds response for child 2 while others accepted; new requests on that ID stall until child 2 accepts.
REQ-034 rst_ni low for 1 cycle while ID 1 in WAIT_PARENT -> all outputs 0; later dn_valid_i ID 1 -> err_dn_o pulse.
